uart_tx_param: RTL and testbench

Parametrised RS-232 transmitter, the successor to the fixed 8-data/2-stop/no-parity transmitter in the serial port path.
- Data width, stop-bit count and parity mode are set at elaboration.
- A one-entry holding register allows back-to-back frames with no idle bit between them.
- Bit timing comes from an external single-cycle BitTick strobe, shared with the existing baud generator.

---
 rtl/uart_tx_param.sv | 131 +++++++++++++
 tb/tb_uart_tx_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised RS-232 transmitter with a one-entry holding register.
// Bit timing comes from an external one-clock BitTick strobe.
module uart_tx_param #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 2,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 BitTick,
    input  logic                 TxD_start,
    input  logic [DATA_BITS-1:0] TxD_data,
    output logic                 TxD,
    output logic                 TBR,
    output logic                 busy
);

    localparam int               CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
            $error("uart_tx_param: DATA_BITS must be 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : gBadParity
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
    endgenerate

    logic [2:0]           state;
    logic                 holdValid;
    logic [DATA_BITS-1:0] holdData;
    logic [DATA_BITS-1:0] shiftReg;
    logic [CNT_W-1:0]     bitCnt;
    logic                 stopCnt;
    logic                 parityBit;
    logic                 frameParity;
    logic                 transfer;

    always_comb begin
        frameParity = 1'b0;
        if (PARITY == 1) begin
            frameParity = ~^holdData;
        end else if (PARITY == 2) begin
            frameParity = ^holdData;
        end
    end

    // A queued character is loaded straight from idle or on the tick that ends
    // the last stop bit, so consecutive frames have no idle gap.
    assign transfer = holdValid &&
                      ((state == S_IDLE) ||
                       (state == S_STOP && BitTick && stopCnt == LAST_STOP));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            holdValid <= 1'b0;
            holdData  <= '0;
            shiftReg  <= '0;
            bitCnt    <= '0;
            stopCnt   <= 1'b0;
            parityBit <= 1'b0;
        end else begin
            if (TxD_start && !holdValid) begin
                holdData  <= TxD_data;
                holdValid <= 1'b1;
            end

            if (transfer) begin
                shiftReg  <= holdData;
                parityBit <= frameParity;
                holdValid <= 1'b0;
                state     <= S_START;
            end else if (BitTick) begin
                case (state)
                    S_IDLE: ;
                    S_START: begin
                        state  <= S_DATA;
                        bitCnt <= '0;
                    end
                    S_DATA: begin
                        shiftReg <= shiftReg >> 1;
                        bitCnt   <= bitCnt + 1'b1;
                        if (bitCnt == LAST_BIT) begin
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                            stopCnt <= 1'b0;
                        end
                    end
                    S_PARITY: begin
                        state   <= S_STOP;
                        stopCnt <= 1'b0;
                    end
                    S_STOP: begin
                        if (stopCnt == LAST_STOP) begin
                            state <= S_IDLE;
                        end else begin
                            stopCnt <= stopCnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // The line is decoded from registers only, so input glitches never reach it.
    always_comb begin
        TxD = 1'b1;
        case (state)
            S_START:  TxD = 1'b0;
            S_DATA:   TxD = shiftReg[0];
            S_PARITY: TxD = parityBit;
            default:  TxD = 1'b1;
        endcase
    end

    assign TBR  = ~holdValid;
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: five configurations share clk, reset and a
// BitTick every 16 clocks; frames are sampled on the cycle carrying each tick.
module tb_uart_tx_param;

    logic       clk;
    logic       rst_n;
    logic       BitTick;
    logic [4:0] startV;
    logic [7:0] td0, td1, td2;
    logic [6:0] td3;
    logic [4:0] td4;
    logic [4:0] txd, tbr, busy;
    int         tickCnt;
    int         checks;
    int         failures;
    logic [31:0] frame;

    uart_tx_param dut8n2 (
        .clk(clk), .rst_n(rst_n), .BitTick(BitTick), .TxD_start(startV[0]),
        .TxD_data(td0), .TxD(txd[0]), .TBR(tbr[0]), .busy(busy[0]));

    uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(2)) dut8e1 (
        .clk(clk), .rst_n(rst_n), .BitTick(BitTick), .TxD_start(startV[1]),
        .TxD_data(td1), .TxD(txd[1]), .TBR(tbr[1]), .busy(busy[1]));

    uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(1)) dut8o1 (
        .clk(clk), .rst_n(rst_n), .BitTick(BitTick), .TxD_start(startV[2]),
        .TxD_data(td2), .TxD(txd[2]), .TBR(tbr[2]), .busy(busy[2]));

    uart_tx_param #(.DATA_BITS(7), .STOP_BITS(1), .PARITY(1)) dut7o1 (
        .clk(clk), .rst_n(rst_n), .BitTick(BitTick), .TxD_start(startV[3]),
        .TxD_data(td3), .TxD(txd[3]), .TBR(tbr[3]), .busy(busy[3]));

    uart_tx_param #(.DATA_BITS(5), .STOP_BITS(1), .PARITY(0)) dut5n1 (
        .clk(clk), .rst_n(rst_n), .BitTick(BitTick), .TxD_start(startV[4]),
        .TxD_data(td4), .TxD(txd[4]), .TBR(tbr[4]), .busy(busy[4]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BitTick changes just after a rising edge so it is stable at every negedge.
    initial begin
        BitTick = 1'b0;
        tickCnt = 0;
        forever begin
            @(posedge clk);
            #2;
            tickCnt = (tickCnt + 1) % 16;
            BitTick = (tickCnt == 15);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitTick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!BitTick && n < 64);
        if (!BitTick) checkOutput("tickTimeout", 32'(BitTick), 32'd1);
    endtask

    task automatic collectFrame(input int id, input int n, output logic [31:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            waitTick();
            bits[i] = txd[id];
        end
    endtask

    task automatic applyStimulus(input int id, input logic [8:0] value, input bit alignTick);
        if (alignTick) waitTick();
        @(negedge clk);
        case (id)
            0: td0 = value[7:0];
            1: td1 = value[7:0];
            2: td2 = value[7:0];
            3: td3 = value[6:0];
            default: td4 = value[4:0];
        endcase
        startV[id] = 1'b1;
        @(negedge clk);
        startV[id] = 1'b0;
        checkOutput("tbrLowAfterWrite", 32'(tbr[id]), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        startV   = '0;
        td0 = '0; td1 = '0; td2 = '0; td3 = '0; td4 = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetTxD", 32'(txd), 32'h1F);
        checkOutput("resetTbr", 32'(tbr), 32'h1F);
        checkOutput("resetBusy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] 8N2 frame 0xA5");
        applyStimulus(0, 9'h0A5, 1'b1);
        @(negedge clk);
        checkOutput("tbrHighAfterTransfer", 32'(tbr[0]), 32'd1);
        checkOutput("busyAfterTransfer", 32'(busy[0]), 32'd1);
        collectFrame(0, 11, frame);
        checkOutput("frame8n2A5", frame, 32'b111_0100_1010);
        @(negedge clk);
        checkOutput("busyFallAfterStop2", 32'(busy[0]), 32'd0);
        checkOutput("idleLine8n2", 32'(txd[0]), 32'd1);

        $display("[TB] parity frames");
        applyStimulus(1, 9'h007, 1'b1);
        collectFrame(1, 11, frame);
        checkOutput("frame8e1x07", frame, {21'd0, 1'b1, 1'b1, 8'h07, 1'b0});
        @(negedge clk);
        checkOutput("busyEnd8e1", 32'(busy[1]), 32'd0);
        applyStimulus(2, 9'h007, 1'b1);
        collectFrame(2, 11, frame);
        checkOutput("frame8o1x07", frame, {21'd0, 1'b1, 1'b0, 8'h07, 1'b0});
        applyStimulus(3, 9'h000, 1'b1);
        collectFrame(3, 10, frame);
        checkOutput("frame7o1x00", frame, {22'd0, 1'b1, 1'b1, 7'h00, 1'b0});

        $display("[TB] back-to-back 0x55 then 0x0F");
        applyStimulus(0, 9'h055, 1'b1);
        for (int n = 0; n < 64 && !tbr[0]; n++) @(negedge clk);
        checkOutput("tbrBeforeSecondWrite", 32'(tbr[0]), 32'd1);
        applyStimulus(0, 9'h00F, 1'b0);
        collectFrame(0, 22, frame);
        checkOutput("frameBackToBack", frame,
                    {10'd0, 2'b11, 8'h0F, 1'b0, 2'b11, 8'h55, 1'b0});
        @(negedge clk);
        checkOutput("busyEndBackToBack", 32'(busy[0]), 32'd0);

        $display("[TB] write while TBR low is ignored");
        applyStimulus(0, 9'h012, 1'b1);
        td0       = 8'hFF;
        startV[0] = 1'b1;
        @(negedge clk);
        startV[0] = 1'b0;
        checkOutput("tbrAfterIgnoredWrite", 32'(tbr[0]), 32'd1);
        collectFrame(0, 11, frame);
        checkOutput("frameIgnoredFF", frame, {21'd0, 2'b11, 8'h12, 1'b0});
        for (int i = 0; i < 2; i++) begin
            waitTick();
            checkOutput("idleTxDAfterIgnored", 32'(txd[0]), 32'd1);
            checkOutput("idleBusyAfterIgnored", 32'(busy[0]), 32'd0);
        end

        $display("[TB] reset during data bits");
        applyStimulus(0, 9'h000, 1'b1);
        collectFrame(0, 3, frame);
        @(negedge clk);
        checkOutput("midFrameLine", 32'(txd[0]), 32'd0);
        checkOutput("midFrameBusy", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abortTxD", 32'(txd[0]), 32'd1);
        checkOutput("abortTbr", 32'(tbr[0]), 32'd1);
        checkOutput("abortBusy", 32'(busy[0]), 32'd0);
        applyStimulus(0, 9'h03C, 1'b1);
        collectFrame(0, 11, frame);
        checkOutput("frameAfterAbort3C", frame, {21'd0, 2'b11, 8'h3C, 1'b0});

        $display("[TB] 5N1 frame 0x1B");
        applyStimulus(4, 9'h01B, 1'b1);
        collectFrame(4, 7, frame);
        checkOutput("frame5n1x1B", frame, 32'b111_0110);
        @(negedge clk);
        checkOutput("busyEnd5n1", 32'(busy[4]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
